// File: rtl/vram_pkg.sv
// Shared types and sizes for the VRAM port-B arbiter.
// Imported by the interface, the fill engine and the top.
package vram_pkg;

  localparam int VRAM_AW = 11;
  localparam int VRAM_DW = 32;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_FILL
  } grant_t;

endpackage

// File: rtl/vram_port_b_arbiter_if.sv
// Avalon-MM slave bundle between the CPU fabric and the arbiter.
// The CPU side is the master; the arbiter is the slave.
interface vram_port_b_arbiter_if
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
);

  logic [AW-1:0]   AVL_ADDR;
  logic            AVL_WREN;
  logic            AVL_REN;
  logic [DW/8-1:0] AVL_BYTE_EN;
  logic [DW-1:0]   AVL_WRITEDATA;
  logic [DW-1:0]   AVL_READDATA;
  logic            AVL_WAITREQ;

  modport master (
    output AVL_ADDR,
    output AVL_WREN,
    output AVL_REN,
    output AVL_BYTE_EN,
    output AVL_WRITEDATA,
    input  AVL_READDATA,
    input  AVL_WAITREQ
  );

  modport slave (
    input  AVL_ADDR,
    input  AVL_WREN,
    input  AVL_REN,
    input  AVL_BYTE_EN,
    input  AVL_WRITEDATA,
    output AVL_READDATA,
    output AVL_WAITREQ
  );

endinterface

// File: rtl/vram_fill_engine.sv
// Fill engine: latches a fill job and offers one word per cycle.
// The word advances only when the arbiter grants it.
module vram_fill_engine
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [AW:0]   fill_len,
  input  logic [DW-1:0] fill_pattern,
  input  logic          i_grant,
  output logic          o_offer,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          fill_busy,
  output logic          fill_done
);

  fill_state_t   r_state;
  logic [AW-1:0] r_base;
  logic [AW:0]   r_len;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_pat;
  logic          r_busy;
  logic          r_done;
  logic [AW:0]   w_next_cnt;

  assign w_next_cnt = r_cnt + 1'b1;

  // Address wraps naturally at 2^AW.
  assign o_addr    = r_base + r_cnt[AW-1:0];
  assign o_data    = r_pat;
  assign o_offer   = r_busy;
  assign fill_busy = r_busy;
  assign fill_done = r_done;

  // Fill FSM with job latch, word counter and registered flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        FILL_IDLE: begin
          if (fill_start) begin
            r_base <= fill_base;
            r_len  <= fill_len;
            r_pat  <= fill_pattern;
            r_cnt  <= '0;
            if (fill_len == '0) begin
              r_state <= FILL_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FILL_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        FILL_RUN: begin
          if (i_grant) begin
            r_cnt <= w_next_cnt;
            if (w_next_cnt == r_len) begin
              r_state <= FILL_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        FILL_DONE: begin
          r_state <= FILL_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= FILL_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vram_port_b_arbiter.sv
// Round-robin share of VRAM port B between Avalon CPU and fill.
// Read data is registered; waitrequest drops the cycle after capture.
module vram_port_b_arbiter
  import vram_pkg::*;
#(
  parameter int AW         = VRAM_AW,
  parameter int DW         = VRAM_DW,
  parameter int RD_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  vram_port_b_arbiter_if.slave avl,
  input  logic            fill_start,
  input  logic [AW-1:0]   fill_base,
  input  logic [AW:0]     fill_len,
  input  logic [DW-1:0]   fill_pattern,
  output logic            fill_busy,
  output logic            fill_done,
  output logic [AW-1:0]   vram_addr,
  output logic            vram_wren,
  output logic            vram_ren,
  output logic [DW/8-1:0] vram_byte_en,
  output logic [DW-1:0]   vram_wdata,
  input  logic [DW-1:0]   vram_rdata
);

  grant_t        r_last_grant;
  logic [1:0]    r_rd_cnt;
  logic          r_rd_served;
  logic [DW-1:0] r_rd_data;

  logic          w_fill_offer;
  logic [AW-1:0] w_fill_addr;
  logic [DW-1:0] w_fill_data;
  logic          w_rd_pending;
  logic          w_rd_capture;
  logic          w_cpu_wr;
  logic          w_cpu_rd;
  logic          w_gnt_cpu;
  logic          w_gnt_fill;
  logic          w_rd_issue;

  vram_fill_engine #(
    .AW (AW),
    .DW (DW)
  ) u_fill (
    .clock        (clock),
    .reset_n      (reset_n),
    .fill_start   (fill_start),
    .fill_base    (fill_base),
    .fill_len     (fill_len),
    .fill_pattern (fill_pattern),
    .i_grant      (w_gnt_fill),
    .o_offer      (w_fill_offer),
    .o_addr       (w_fill_addr),
    .o_data       (w_fill_data),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done)
  );

  assign w_rd_pending = (r_rd_cnt != 2'd0);
  assign w_rd_capture = (r_rd_cnt == 2'd1);

  // Write wins when both strobes are up; a held read is not re-issued.
  assign w_cpu_wr = avl.AVL_WREN;
  assign w_cpu_rd = avl.AVL_REN & ~avl.AVL_WREN
                  & ~w_rd_pending & ~r_rd_served;

  // reset_n gating keeps port B quiet while reset is asserted.
  assign w_gnt_cpu = reset_n & (w_cpu_wr | w_cpu_rd)
                   & (~w_fill_offer | (r_last_grant == GNT_FILL));
  assign w_gnt_fill = reset_n & w_fill_offer & ~w_gnt_cpu;
  assign w_rd_issue = w_gnt_cpu & w_cpu_rd;

  assign avl.AVL_READDATA = r_rd_data;
  assign avl.AVL_WAITREQ  = ~((w_gnt_cpu & w_cpu_wr) | r_rd_served);

  // Port-B mux driven straight from the grant.
  always_comb begin
    vram_addr    = '0;
    vram_wren    = 1'b0;
    vram_ren     = 1'b0;
    vram_byte_en = '0;
    vram_wdata   = '0;
    unique case (1'b1)
      w_gnt_cpu: begin
        vram_addr    = avl.AVL_ADDR;
        vram_byte_en = avl.AVL_BYTE_EN;
        vram_wdata   = avl.AVL_WRITEDATA;
        vram_wren    = w_cpu_wr;
        vram_ren     = w_cpu_rd;
      end
      w_gnt_fill: begin
        vram_addr    = w_fill_addr;
        vram_byte_en = '1;
        vram_wdata   = w_fill_data;
        vram_wren    = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant history plus read latency counter and capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GNT_CPU;
      r_rd_cnt     <= 2'd0;
      r_rd_served  <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      if (w_gnt_cpu) begin
        r_last_grant <= GNT_CPU;
      end else if (w_gnt_fill) begin
        r_last_grant <= GNT_FILL;
      end
      if (w_rd_issue) begin
        r_rd_cnt <= 2'(RD_LATENCY);
      end else if (w_rd_pending) begin
        r_rd_cnt <= r_rd_cnt - 2'd1;
      end
      if (w_rd_capture) begin
        r_rd_data <= vram_rdata;
      end
      r_rd_served <= w_rd_capture;
    end
  end

endmodule
